// File: rtl/sha256_unpadder_if.sv
`timescale 1ns/1ps
// Stream bundle for sha256_unpadder: padded 512-bit blocks in (two beats each),
// recovered message beats out with padbytes/last/err.
interface sha256_unpadder_if #(
    parameter int DATA_W  = 256,
    parameter int BYTES_W = $clog2(DATA_W/8)+1
);
    logic               in_data_val;
    logic [DATA_W-1:0]  in_data;
    logic               in_data_last;
    logic               in_rdy;
    logic               out_data_val;
    logic [DATA_W-1:0]  out_data;
    logic [BYTES_W-1:0] out_data_padbytes;
    logic               out_data_last;
    logic               out_err;
    logic               out_rdy;

    modport slave (
        input  in_data_val, in_data, in_data_last, out_rdy,
        output in_rdy, out_data_val, out_data, out_data_padbytes, out_data_last, out_err
    );

    modport master (
        output in_data_val, in_data, in_data_last, out_rdy,
        input  in_rdy, out_data_val, out_data, out_data_padbytes, out_data_last, out_err
    );
endinterface

// File: rtl/sha256_unpadder.sv
`timescale 1ns/1ps
// Strips SHA-256 padding from a stream of two-beat blocks, using the trailing
// 64-bit bit-length to decide how many held beats are message data.
module sha256_unpadder #(
    parameter int DATA_W  = 256,
    parameter int BYTES_W = $clog2(DATA_W/8)+1
) (
    input  logic             clk,
    input  logic             rst_n,
    sha256_unpadder_if.slave bus
);
    localparam int BEAT_B = DATA_W/8;
    localparam logic [BYTES_W-1:0] BEAT_B_W = BYTES_W'(BEAT_B);

    typedef enum logic [1:0] {ST_STREAM, ST_CALC, ST_DRAIN, ST_LASTZERO} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  fifo_q [3];
    logic [DATA_W-1:0]  fifo_d [3];
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [1:0]         h_q, h_d;
    logic [63:0]        n_q, n_d;
    logic [63:0]        len_q, len_d;
    logic [1:0]         r_q, r_d;
    logic               err_q, err_d;
    logic [BYTES_W-1:0] pad_q, pad_d;
    logic               rdy_en_q, rdy_en_d;

    logic [63:0]        msg_bytes, data_beats, emitted, r_raw;
    logic [65:0]        exp_beats;
    logic [1:0]         r_calc;
    logic               err_calc;
    logic [BYTES_W-1:0] tail_bytes, pad_calc;

    // Length-field decode; only meaningful while in ST_CALC.
    always_comb begin
        msg_bytes  = len_q >> 3;
        data_beats = (msg_bytes + 64'(BEAT_B - 1)) / 64'(BEAT_B);
        emitted    = n_q - {62'd0, h_q};
        exp_beats  = (({2'b00, len_q} + 66'd583) >> 9) << 1;
        r_raw      = (data_beats >= emitted) ? (data_beats - emitted) : 64'd0;
        r_calc     = (r_raw > {62'd0, h_q}) ? h_q : r_raw[1:0];
        err_calc   = (len_q[2:0] != 3'd0) | ({2'b00, n_q} != exp_beats)
                   | (data_beats < emitted) | (&n_q);
        tail_bytes = BYTES_W'(msg_bytes - ((data_beats - 64'd1) * 64'(BEAT_B)));
        pad_calc   = BEAT_B_W - tail_bytes;
    end

    logic               in_rdy_c, out_val_c, out_last_c, out_err_c;
    logic [DATA_W-1:0]  out_data_c, head, keep_mask;
    logic [BYTES_W-1:0] out_pad_c, keep_bytes;
    logic               accept, pop;
    logic [2:0]         wr_sum;
    logic [1:0]         wr_idx, rd_next;

    always_comb begin
        head = (rd_ptr_q == 2'd2) ? fifo_q[2] : (rd_ptr_q == 2'd1) ? fifo_q[1] : fifo_q[0];
        keep_bytes = BEAT_B_W - pad_q;
        for (int i = 0; i < BEAT_B; i++) begin
            keep_mask[DATA_W-1-8*i -: 8] = (BYTES_W'(i) < keep_bytes) ? 8'hFF : 8'h00;
        end

        in_rdy_c   = rdy_en_q & (state_q == ST_STREAM) & ((h_q != 2'd3) | bus.out_rdy);
        out_val_c  = 1'b0;
        out_data_c = '0;
        out_pad_c  = '0;
        out_last_c = 1'b0;
        out_err_c  = 1'b0;

        state_d  = state_q;
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        h_d      = h_q;
        n_d      = n_q;
        len_d    = len_q;
        r_d      = r_q;
        err_d    = err_q;
        pad_d    = pad_q;
        rdy_en_d = 1'b1;

        rd_next = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
        wr_sum  = {1'b0, rd_ptr_q} + {1'b0, h_q};
        wr_idx  = (wr_sum >= 3'd3) ? 2'(wr_sum - 3'd3) : wr_sum[1:0];

        case (state_q)
            ST_STREAM: begin
                out_val_c  = (h_q == 2'd3);
                out_data_c = out_val_c ? head : '0;
            end
            ST_DRAIN: begin
                out_val_c  = 1'b1;
                out_last_c = (r_q == 2'd1);
                out_data_c = out_last_c ? (head & keep_mask) : head;
                out_pad_c  = out_last_c ? pad_q : '0;
                out_err_c  = out_last_c & err_q;
            end
            ST_LASTZERO: begin
                out_val_c  = 1'b1;
                out_pad_c  = BEAT_B_W;
                out_last_c = 1'b1;
                out_err_c  = err_q;
            end
            default: ;
        endcase

        accept = bus.in_data_val & in_rdy_c;
        pop    = out_val_c & bus.out_rdy;

        case (state_q)
            ST_STREAM: begin
                // A full buffer may pop and refill in the same cycle.
                if (pop) rd_ptr_d = rd_next;
                if (accept) begin
                    for (int i = 0; i < 3; i++) begin
                        if (2'(i) == wr_idx) fifo_d[i] = bus.in_data;
                    end
                    if (n_q != '1) n_d = n_q + 64'd1;
                    if (bus.in_data_last) begin
                        len_d   = bus.in_data[63:0];
                        state_d = ST_CALC;
                    end
                end
                h_d = h_q + {1'b0, accept} - {1'b0, pop};
            end
            ST_CALC: begin
                r_d     = r_calc;
                err_d   = err_calc;
                pad_d   = pad_calc;
                state_d = (r_calc == 2'd0) ? ST_LASTZERO : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop) begin
                    if (r_q == 2'd1) begin
                        h_d      = 2'd0;
                        n_d      = 64'd0;
                        rd_ptr_d = 2'd0;
                        state_d  = ST_STREAM;
                    end else begin
                        rd_ptr_d = rd_next;
                        h_d      = h_q - 2'd1;
                        r_d      = r_q - 2'd1;
                    end
                end
            end
            ST_LASTZERO: begin
                if (pop) begin
                    h_d      = 2'd0;
                    n_d      = 64'd0;
                    rd_ptr_d = 2'd0;
                    state_d  = ST_STREAM;
                end
            end
            default: state_d = ST_STREAM;
        endcase
    end

    assign bus.in_rdy            = in_rdy_c;
    assign bus.out_data_val      = out_val_c;
    assign bus.out_data          = out_data_c;
    assign bus.out_data_padbytes = out_pad_c;
    assign bus.out_data_last     = out_last_c;
    assign bus.out_err           = out_err_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STREAM;
            for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
            rd_ptr_q <= 2'd0;
            h_q      <= 2'd0;
            n_q      <= 64'd0;
            len_q    <= 64'd0;
            r_q      <= 2'd0;
            err_q    <= 1'b0;
            pad_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            h_q      <= h_d;
            n_q      <= n_d;
            len_q    <= len_d;
            r_q      <= r_d;
            err_q    <= err_d;
            pad_q    <= pad_d;
            rdy_en_q <= rdy_en_d;
        end
    end
endmodule

// File: tb/tb_sha256_unpadder.sv
`timescale 1ns/1ps
// Scoreboard bench for sha256_unpadder: messages are padded by a byte-level
// model, and the expected message beats are queued for an independent monitor.
module tb_sha256_unpadder;
    localparam int DATA_W  = 256;
    localparam int BYTES_W = 6;

    typedef logic [DATA_W-1:0] beat_t;
    typedef struct {
        beat_t              data;
        logic [BYTES_W-1:0] pad;
        logic               last;
        logic               err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    beat_t stim_q[$];
    byte unsigned msg_q[$];
    bit busy = 1'b0;
    int rdy_mode = 0;

    sha256_unpadder_if #(.DATA_W(DATA_W), .BYTES_W(BYTES_W)) bus ();

    sha256_unpadder #(.DATA_W(DATA_W), .BYTES_W(BYTES_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input beat_t act, input beat_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic failNow(input string name, input int act);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got %0d, expected 0", name, act);
    endtask

    // Out-ready pattern: 0 = always ready, 1 = random stalls, 2 = held off.
    initial begin
        bus.out_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_rdy = 1'b1;
                1:       bus.out_rdy = ($urandom_range(0, 99) < 60);
                default: bus.out_rdy = 1'b0;
            endcase
        end
    end

    // Monitor: compares every output handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) checkOutput("in_rdy_low_after_last", DATA_W'(bus.in_rdy), '0);
                if (bus.out_data_val && bus.out_rdy) begin
                    if (exp_q.size() == 0) begin
                        failNow("unexpected_beat", 1);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("data", bus.out_data, e.data);
                        checkOutput("padbytes", DATA_W'(bus.out_data_padbytes), DATA_W'(e.pad));
                        checkOutput("last", DATA_W'(bus.out_data_last), DATA_W'(e.last));
                        checkOutput("err", DATA_W'(bus.out_err), DATA_W'(e.err));
                    end
                    if (bus.out_data_last) busy = 1'b0;
                end
            end
        end
    end

    task automatic randMsg(input int m);
        msg_q.delete();
        for (int i = 0; i < m; i++) msg_q.push_back(8'($urandom));
    endtask

    // Standard SHA-256 padding at byte level, then split into 32-byte beats.
    task automatic buildPadded(input logic [63:0] len);
        byte unsigned bytes_q[$];
        beat_t b;
        bytes_q = msg_q;
        bytes_q.push_back(8'h80);
        while (bytes_q.size() % 64 != 56) bytes_q.push_back(8'h00);
        for (int i = 7; i >= 0; i--) bytes_q.push_back(len[8*i +: 8]);
        stim_q.delete();
        for (int k = 0; k < bytes_q.size() / 32; k++) begin
            for (int j = 0; j < 32; j++) b[DATA_W-1-8*j -: 8] = bytes_q[32*k+j];
            stim_q.push_back(b);
        end
    endtask

    task automatic pushRaw(input beat_t data, input int pad, input bit last, input bit err);
        exp_t e;
        e.data = data;
        e.pad  = BYTES_W'(pad);
        e.last = last;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Expected message beats: bytes packed from the top, unused tail bytes zero.
    task automatic expectMessage(input bit err);
        int m;
        int d;
        beat_t b;
        m = msg_q.size();
        d = (m + 31) / 32;
        if (m == 0) begin
            pushRaw('0, 32, 1'b1, err);
        end else begin
            for (int k = 0; k < d; k++) begin
                b = '0;
                for (int j = 0; j < 32; j++)
                    if (32*k + j < m) b[DATA_W-1-8*j -: 8] = msg_q[32*k+j];
                pushRaw(b, (k == d-1) ? 32*d - m : 0, k == d-1, (k == d-1) ? err : 1'b0);
            end
        end
    endtask

    task automatic applyStimulus(input bit gaps);
        int wait_cnt;
        for (int k = 0; k < stim_q.size(); k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_data_val = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            bus.in_data_val  = 1'b1;
            bus.in_data      = stim_q[k];
            bus.in_data_last = (k == stim_q.size() - 1);
            wait_cnt = 0;
            forever begin
                @(negedge clk);
                if (bus.in_rdy || wait_cnt > 2000) break;
                wait_cnt++;
            end
            @(posedge clk);
            #1;
            if (wait_cnt > 2000) failNow("in_accept_timeout", wait_cnt);
            else if (k == stim_q.size() - 1) busy = 1'b1;
        end
        bus.in_data_val  = 1'b0;
        bus.in_data_last = 1'b0;
    endtask

    task automatic waitDrain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || busy) && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 5000) failNow("drain_timeout", exp_q.size());
    endtask

    task automatic sendValid(input int m, input bit gaps);
        randMsg(m);
        buildPadded(64'(8*m));
        expectMessage(1'b0);
        applyStimulus(gaps);
    endtask

    initial begin
        beat_t r0, r1, r2;
        int m;
        bus.in_data_val  = 1'b0;
        bus.in_data      = '0;
        bus.in_data_last = 1'b0;

        #1 rst_n = 1'b0;
        #11;
        checkOutput("reset_out_val", DATA_W'(bus.out_data_val), '0);
        checkOutput("reset_out_last", DATA_W'(bus.out_data_last), '0);
        checkOutput("reset_out_err", DATA_W'(bus.out_err), '0);
        checkOutput("reset_out_data", bus.out_data, '0);
        checkOutput("reset_padbytes", DATA_W'(bus.out_data_padbytes), '0);
        checkOutput("reset_in_rdy", DATA_W'(bus.in_rdy), '0);
        rst_n = 1'b1;
        #1 checkOutput("in_rdy_before_edge", DATA_W'(bus.in_rdy), '0);
        @(posedge clk);
        #1 checkOutput("in_rdy_after_reset", DATA_W'(bus.in_rdy), DATA_W'(1));

        $display("[TB] directed: abc, empty, 60 and 64 byte messages");
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        buildPadded(64'd24);
        expectMessage(1'b0);
        applyStimulus(1'b0);
        sendValid(0, 1'b0);
        sendValid(60, 1'b0);
        sendValid(64, 1'b0);

        $display("[TB] backpressure: 640 byte message");
        rdy_mode = 1;
        sendValid(640, 1'b1);
        waitDrain();

        $display("[TB] errors: short message, empty-length underflow, bad bit length");
        r0 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        stim_q.delete();
        stim_q.push_back(r0);
        stim_q.push_back(beat_t'(64'h200));
        pushRaw(r0, 0, 1'b0, 1'b0);
        pushRaw(beat_t'(64'h200), 0, 1'b1, 1'b1);
        applyStimulus(1'b1);

        r1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        stim_q.delete();
        stim_q.push_back(r0); stim_q.push_back(r1); stim_q.push_back(r2);
        stim_q.push_back(r1); stim_q.push_back(r2); stim_q.push_back('0);
        pushRaw(r0, 0, 1'b0, 1'b0);
        pushRaw(r1, 0, 1'b0, 1'b0);
        pushRaw(r2, 0, 1'b0, 1'b0);
        pushRaw('0, 32, 1'b1, 1'b1);
        applyStimulus(1'b1);

        m = int'($urandom_range(1, 100));
        randMsg(m);
        buildPadded(64'(8*m + int'($urandom_range(1, 7))));
        expectMessage(1'b1);
        applyStimulus(1'b1);
        waitDrain();

        $display("[TB] reset while draining");
        rdy_mode = 2;
        @(posedge clk);
        #1;
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        buildPadded(64'd24);
        applyStimulus(1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drain_out_val", DATA_W'(bus.out_data_val), DATA_W'(1));
        checkOutput("drain_out_last", DATA_W'(bus.out_data_last), DATA_W'(1));
        checkOutput("drain_in_rdy", DATA_W'(bus.in_rdy), '0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_val", DATA_W'(bus.out_data_val), '0);
        checkOutput("midreset_out_data", bus.out_data, '0);
        checkOutput("midreset_out_last", DATA_W'(bus.out_data_last), '0);
        busy = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 1;
        @(posedge clk);
        #1;
        sendValid(45, 1'b1);
        waitDrain();

        $display("[TB] random messages");
        for (int t = 0; t < 12; t++) begin
            rdy_mode = int'($urandom_range(0, 1));
            sendValid(int'($urandom_range(0, 200)), 1'($urandom_range(0, 1)));
        end
        waitDrain();
        checkOutput("scoreboard_empty", DATA_W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
